uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receiver. It detects the start-bit falling edge on `rx_in` and counts oversampling edges and bit positions. It issues the one-cycle enables that drive the sampler, deserializer and the start, parity and stop checkers, then qualifies the received byte with `data_valid`. It sits between the raw RX line and the RX datapath checkers, and owns all frame timing.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_edge_bit_counter.sv | 38 +++
 rtl/uart_rx_fsm.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: state encoding, legal
// oversampling ratios and the sample/evaluate offsets within a bit.
package uart_rx_pkg;

  localparam int unsigned PS_W  = 6;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned ST_W  = 3;

  // Frame sequencer state encoding
  typedef logic [ST_W-1:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // Legal oversampling ratios; anything else falls back to PS_8
  localparam logic [PS_W-1:0] PS_8  = 6'd8;
  localparam logic [PS_W-1:0] PS_16 = 6'd16;
  localparam logic [PS_W-1:0] PS_32 = 6'd32;

  // SAMP = ps/2 + SAMP_OFS (majority-of-3 valid), EVAL = ps/2 + EVAL_OFS
  localparam logic [PS_W-1:0] SAMP_OFS = 6'd2;
  localparam logic [PS_W-1:0] EVAL_OFS = 6'd3;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter and bit-position counter for one UART frame.
// Both counts are forced to zero whenever the counter is not enabled.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = PS_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [PRESCALE_WIDTH-1:0] i_ps_q,
  output logic [PRESCALE_WIDTH-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]          o_bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [PRESCALE_WIDTH-1:0] w_last;

  assign w_last = i_ps_q - PRESCALE_WIDTH'(1);

  // Edge count wraps at the last oversampling edge and advances the bit count
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_edge_cnt == w_last) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: detects the start edge, walks the frame
// bit by bit and issues single-cycle strobes to the sampler, deserializer
// and checkers. Strobes are registered one edge ahead (SAMP-1) so they land
// exactly on edge SAMP without combinational decode on the outputs.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = PS_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_rx_in,
  input  logic                      i_par_en,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  input  logic                      i_strt_glitch,
  input  logic                      i_par_err,
  input  logic                      i_stp_err,
  output logic [PRESCALE_WIDTH-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]          o_bit_cnt,
  output logic                      o_dat_samp_en,
  output logic                      o_deser_en,
  output logic                      o_strt_chk_en,
  output logic                      o_par_chk_en,
  output logic                      o_stp_chk_en,
  output logic                      o_data_valid,
  output logic                      o_busy
);

  localparam int unsigned PW = PRESCALE_WIDTH;
  localparam logic [PW-1:0] C_PS_8     = PW'(PS_8);
  localparam logic [PW-1:0] C_PS_16    = PW'(PS_16);
  localparam logic [PW-1:0] C_PS_32    = PW'(PS_32);
  localparam logic [PW-1:0] C_SAMP_OFS = PW'(SAMP_OFS);
  localparam logic [PW-1:0] C_EVAL_OFS = PW'(EVAL_OFS);

  state_t          r_state;
  state_t          w_next_state;
  logic [PW-1:0]   r_ps_q;
  logic [PW-1:0]   w_ps_legal;

  logic [PW-1:0]   w_edge_cnt;
  logic [BIT_W-1:0] w_bit_cnt;
  logic            w_cnt_en;

  logic [PW-1:0]   w_pre_samp;
  logic [PW-1:0]   w_last;
  logic [PW-1:0]   w_eval;
  logic            w_at_pre_samp;
  logic            w_at_last;
  logic            w_at_eval;
  logic            w_last_data_bit;
  logic            w_frame_ok;

  logic            r_dat_samp_en;
  logic            r_deser_en;
  logic            r_strt_chk_en;
  logic            r_par_chk_en;
  logic            r_stp_chk_en;
  logic            r_data_valid;
  logic            r_busy;

  function automatic logic is_active(input state_t s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_PARITY) || (s == ST_STOP);
  endfunction

  // Illegal oversampling ratios collapse to 8
  assign w_ps_legal = ((i_prescale == C_PS_8) || (i_prescale == C_PS_16) ||
                       (i_prescale == C_PS_32)) ? i_prescale : C_PS_8;

  assign w_pre_samp      = (r_ps_q >> 1) + C_SAMP_OFS - PW'(1);
  assign w_last          = r_ps_q - PW'(1);
  assign w_eval          = (r_ps_q >> 1) + C_EVAL_OFS;
  assign w_at_pre_samp   = (w_edge_cnt == w_pre_samp);
  assign w_at_last       = (w_edge_cnt == w_last);
  assign w_at_eval       = (w_edge_cnt == w_eval);
  assign w_last_data_bit = (w_bit_cnt == BIT_W'(DATA_WIDTH));
  assign w_frame_ok      = !(i_par_en && i_par_err) && !i_stp_err;

  // Counter runs only while staying inside the frame, so it reads zero in IDLE/DONE
  assign w_cnt_en = is_active(r_state) && is_active(w_next_state);

  uart_rx_edge_bit_counter #(
    .PRESCALE_WIDTH (PW)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_cnt_en),
    .i_ps_q     (r_ps_q),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_rx_in) w_next_state = ST_START;
      end
      ST_START: begin
        if (w_at_last) w_next_state = i_strt_glitch ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_at_last && w_last_data_bit) w_next_state = i_par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (w_at_last) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_at_eval) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_next_state = i_rx_in ? ST_IDLE : ST_START;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Oversampling ratio is captured once per frame, on entry to START
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ps_q <= C_PS_8;
    end else if ((r_state == ST_IDLE || r_state == ST_DONE) && w_next_state == ST_START) begin
      r_ps_q <= w_ps_legal;
    end
  end

  // Output strobes registered one edge early so they align with edge SAMP
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dat_samp_en <= 1'b0;
      r_deser_en    <= 1'b0;
      r_strt_chk_en <= 1'b0;
      r_par_chk_en  <= 1'b0;
      r_stp_chk_en  <= 1'b0;
      r_data_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_dat_samp_en <= is_active(w_next_state);
      r_deser_en    <= (r_state == ST_DATA)   && w_at_pre_samp;
      r_strt_chk_en <= (r_state == ST_START)  && w_at_pre_samp;
      r_par_chk_en  <= (r_state == ST_PARITY) && w_at_pre_samp;
      r_stp_chk_en  <= (r_state == ST_STOP)   && w_at_pre_samp;
      r_data_valid  <= (r_state == ST_STOP) && (w_next_state == ST_DONE) && w_frame_ok;
      r_busy        <= (w_next_state != ST_IDLE);
    end
  end

  assign o_edge_cnt    = w_edge_cnt;
  assign o_bit_cnt     = w_bit_cnt;
  assign o_dat_samp_en = r_dat_samp_en;
  assign o_deser_en    = r_deser_en;
  assign o_strt_chk_en = r_strt_chk_en;
  assign o_par_chk_en  = r_par_chk_en;
  assign o_stp_chk_en  = r_stp_chk_en;
  assign o_data_valid  = r_data_valid;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: a table of whole frames with hand-computed
// strobe cycles, plus sequences for start glitch, back-to-back frames and
// mid-frame reset. Frame cycle 0 is the first cycle with busy high.
module tb_uart_rx_fsm;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       busy;

  int total;
  int bad;

  typedef struct {
    int         ps_in;     // value driven on prescale
    int         ps_eff;    // ratio the FSM should actually use
    bit         par_en;
    logic [7:0] data;
    bit         perr;
    bit         serr;
    int         samp;      // expected SAMP edge
    int         exp_par;   // par_chk_en frame cycle, -1 if none
    int         exp_stp;   // stp_chk_en frame cycle
    int         exp_done;  // DONE frame cycle
    int         exp_dv;    // data_valid frame cycle, -1 if none
  } vec_t;

  vec_t vecs [8];

  uart_rx_fsm dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_in       (rx_in),
    .i_par_en      (par_en),
    .i_prescale    (prescale),
    .i_strt_glitch (strt_glitch),
    .i_par_err     (par_err),
    .i_stp_err     (stp_err),
    .o_edge_cnt    (edge_cnt),
    .o_bit_cnt     (bit_cnt),
    .o_dat_samp_en (dat_samp_en),
    .o_deser_en    (deser_en),
    .o_strt_chk_en (strt_chk_en),
    .o_par_chk_en  (par_chk_en),
    .o_stp_chk_en  (stp_chk_en),
    .o_data_valid  (data_valid),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int out_word();
    return int'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                 par_chk_en, stp_chk_en, data_valid, busy});
  endfunction

  // Drive one frame from idle and compare every strobe time against the vector
  task automatic run_frame(input vec_t v, input string tag);
    bit line [0:11];
    int nbits, t, t_rise, fc, limit;
    int strt_fc, deser_n, deser_first, deser_last, deser_off;
    int par_fc, stp_fc, dv_fc, drop_fc, track_bad;
    line[0] = 1'b0;
    for (int i = 0; i < 8; i++) line[i+1] = v.data[i];
    nbits = 9;
    if (v.par_en) begin
      line[9] = ^v.data;
      nbits = 10;
    end
    line[nbits] = 1'b1;
    nbits++;
    strt_fc = -1; deser_n = 0; deser_first = -1; deser_last = -1; deser_off = 0;
    par_fc = -1; stp_fc = -1; dv_fc = -1; drop_fc = -1; track_bad = 0;
    t_rise = -1;
    par_en = v.par_en; prescale = 6'(v.ps_in);
    par_err = v.perr; stp_err = v.serr; strt_glitch = 1'b0;
    rx_in = 1'b0;
    t = 0;
    limit = v.ps_eff * 13 + 20;
    for (int n = 0; n < limit; n++) begin
      tick();
      t++;
      if (t_rise < 0 && busy) t_rise = t;
      if (t_rise >= 0) begin
        fc = t - t_rise;
        if (strt_chk_en && strt_fc < 0) strt_fc = fc;
        if (deser_en) begin
          deser_n++;
          if (deser_first < 0) deser_first = fc;
          deser_last = fc;
          if (fc % v.ps_eff != v.samp) deser_off++;
        end
        if (par_chk_en && par_fc < 0) par_fc = fc;
        if (stp_chk_en && stp_fc < 0) stp_fc = fc;
        if (data_valid && dv_fc < 0) dv_fc = fc;
        if (fc < v.exp_done && (int'(edge_cnt) != fc % v.ps_eff ||
            int'(bit_cnt) != fc / v.ps_eff || !dat_samp_en)) track_bad++;
        if (!busy) begin
          drop_fc = fc;
          break;
        end
      end
      rx_in = (t / v.ps_eff < nbits) ? line[t / v.ps_eff] : 1'b1;
    end
    rx_in = 1'b1; par_err = 1'b0; stp_err = 1'b0;
    check({tag, ".busy_rise"},   t_rise,      1);
    check({tag, ".strt_chk"},    strt_fc,     v.samp);
    check({tag, ".deser_n"},     deser_n,     8);
    check({tag, ".deser_first"}, deser_first, v.ps_eff + v.samp);
    check({tag, ".deser_last"},  deser_last,  8 * v.ps_eff + v.samp);
    check({tag, ".deser_off"},   deser_off,   0);
    check({tag, ".par_chk"},     par_fc,      v.exp_par);
    check({tag, ".stp_chk"},     stp_fc,      v.exp_stp);
    check({tag, ".data_valid"},  dv_fc,       v.exp_dv);
    check({tag, ".busy_drop"},   drop_fc,     v.exp_done + 1);
    check({tag, ".counters"},    track_bad,   0);
    repeat (4) tick();
  endtask

  initial begin
    bit b2b [0:19];
    logic [7:0] d1, d2;
    int t, t_rise, fc, strt_fc, e7, drop_fc, deser_n, dv_n, gap, dv1, dv2, mid, act_n;

    total = 0;
    bad   = 0;

    //            ps_in ps_eff par data   perr serr samp par  stp  done dv
    vecs[0] = '{ 8,  8,  1'b0, 8'h5A, 1'b0, 1'b0, 6,  -1,  78,  80,  80};
    vecs[1] = '{16, 16,  1'b1, 8'hC3, 1'b0, 1'b0, 10, 154, 170, 172, 172};
    vecs[2] = '{32, 32,  1'b0, 8'h81, 1'b0, 1'b0, 18, -1,  306, 308, 308};
    vecs[3] = '{12,  8,  1'b1, 8'h3C, 1'b0, 1'b0, 6,  78,  86,  88,  88};
    vecs[4] = '{ 8,  8,  1'b0, 8'h5A, 1'b0, 1'b1, 6,  -1,  78,  80,  -1};
    vecs[5] = '{16, 16,  1'b1, 8'h0F, 1'b1, 1'b0, 10, 154, 170, 172, -1};
    vecs[6] = '{ 8,  8,  1'b0, 8'hF0, 1'b1, 1'b0, 6,  -1,  78,  80,  80};
    vecs[7] = '{16, 16,  1'b0, 8'h77, 1'b0, 1'b0, 10, -1,  154, 156, 156};

    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    check("reset_outs", out_word(), 0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_outs", out_word(), 0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // Start glitch: line low for two cycles, start check reports not-low
    prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
    t = 0; t_rise = -1; strt_fc = -1; e7 = -1; drop_fc = -1; deser_n = 0; dv_n = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      t++;
      if (t_rise < 0 && busy) t_rise = t;
      fc = (t_rise >= 0) ? t - t_rise : -1;
      if (deser_en) deser_n++;
      if (data_valid) dv_n++;
      if (fc >= 0) begin
        if (strt_chk_en && strt_fc < 0) strt_fc = fc;
        if (fc == 7) e7 = int'(edge_cnt) * 16 + int'(bit_cnt);
        if (!busy && drop_fc < 0) drop_fc = fc;
      end
      rx_in = (t < 2) ? 1'b0 : 1'b1;
      strt_glitch = (fc >= 6 && fc < 8);
    end
    strt_glitch = 1'b0;
    check("glitch.strt_chk",  strt_fc, 6);
    check("glitch.edge7",     e7,      7 * 16 + 0);
    check("glitch.busy_drop", drop_fc, 8);
    check("glitch.deser_n",   deser_n, 0);
    check("glitch.dv_n",      dv_n,    0);

    // Back-to-back frames, second start bit directly after the first stop bit
    d1 = 8'h5A; d2 = 8'hA5;
    b2b[0] = 1'b0; b2b[9] = 1'b1; b2b[10] = 1'b0; b2b[19] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b2b[i+1]  = d1[i];
      b2b[i+11] = d2[i];
    end
    prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
    t = 0; dv1 = -1; dv2 = -1; dv_n = 0; gap = 0; deser_n = 0;
    for (int n = 0; n < 250; n++) begin
      tick();
      t++;
      if (data_valid) begin
        dv_n++;
        if (dv1 < 0) dv1 = t;
        else if (dv2 < 0) dv2 = t;
      end
      if (deser_en) deser_n++;
      if (t <= 162 && !busy) gap++;
      rx_in = (t / 8 < 20) ? b2b[t / 8] : 1'b1;
    end
    rx_in = 1'b1;
    check("b2b.dv1",     dv1,          81);
    check("b2b.dv2",     dv2,          162);
    check("b2b.dv_n",    dv_n,         2);
    check("b2b.gap",     gap,          0);
    check("b2b.deser_n", deser_n,      16);
    check("b2b.idle",    int'(busy),   0);

    // Mid-frame prescale change is ignored; reset during bit 4 aborts the frame
    prescale = 6'd8; par_en = 1'b0; rx_in = 1'b0;
    t = 0; mid = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      t++;
      fc = t - 1;
      if (fc == 16) mid = int'(edge_cnt) * 16 + int'(bit_cnt);
      rx_in = (t / 8 == 0) ? 1'b0 : d1[(t / 8 - 1) % 8];
      if (fc == 10) prescale = 6'd16;
      if (fc == 33) begin
        rst = 1'b1;
        break;
      end
    end
    check("rst.ps_hold", mid, 0 * 16 + 2);
    tick();
    check("rst.outs", out_word(), 0);
    rst = 1'b0;
    rx_in = 1'b1;
    act_n = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy || data_valid || deser_en) act_n++;
    end
    check("rst.quiet", act_n, 0);
    run_frame(vecs[7], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
